// File: rtl/decode_stage.sv
//============================================================================
// Module   : decode_stage  (plus package all_pkgs)
// Purpose  : Registered RV32I/RV64I instruction decode stage. Extracts the
//            register/function fields, classifies the instruction format,
//            builds the sign-extended immediate and flags unsupported
//            encodings. Valid/ready handshake on both sides, one cycle of
//            latency, one instruction per cycle at full throughput.
// Ports    : clk, rst (async, active-high), flush (sync)
//            in_valid/in_ready/in_instr/in_pc      - from fetch
//            out_valid/out_ready/out_pc            - to register read
//            opcode, rd, funct3, rs1, rs2, funct7  - raw instruction fields
//            fmt, imm, rd_we, illegal              - decoded attributes
//            dec_count                             - output transfer counter
// Options  : DECODE_SKID_BUF_EN - adds a one-entry skid register so that
//            in_ready is registered and has no path from out_ready.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package all_pkgs;
   localparam int WIDTH = 32;

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;
endpackage

module decode_stage
   import all_pkgs::*;
#(
   parameter int XLEN  = WIDTH,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [6:0]       opcode,
   output logic [4:0]       rd,
   output logic [2:0]       funct3,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [6:0]       funct7,
   output logic [2:0]       fmt,
   output logic [XLEN-1:0]  imm,
   output logic             rd_we,
   output logic             illegal,
   output logic [CNT_W-1:0] dec_count
);

   // Registered bundle layout: {instr, pc, fmt, imm, rd_we, illegal}
   localparam int BW = 32 + XLEN + 3 + XLEN + 2;

   //------------------------------------------------------------------------
   // Combinational decode of the incoming instruction
   //------------------------------------------------------------------------
   logic [6:0]        w_op;
   logic [2:0]        w_fmt;
   logic              w_illegal;
   logic              w_rd_we;
   logic signed [31:0] w_imm32;
   logic [XLEN-1:0]   w_imm;
   logic [BW-1:0]     w_bundle_in;

   assign w_op = in_instr[6:0];

   always_comb begin
      w_fmt = FMT_ILL;
      case (w_op)
         7'b0110011: w_fmt = FMT_R;
         7'b0010011,
         7'b0000011,
         7'b1100111,
         7'b1110011: w_fmt = FMT_I;
         7'b0100011: w_fmt = FMT_S;
         7'b1100011: w_fmt = FMT_B;
         7'b0110111,
         7'b0010111: w_fmt = FMT_U;
         7'b1101111: w_fmt = FMT_J;
         default:    w_fmt = FMT_ILL;
      endcase
      // Compressed-space encodings are never legal here; every listed
      // opcode already ends in 2'b11, the explicit test keeps intent visible.
      if (in_instr[1:0] != 2'b11) begin
         w_fmt = FMT_ILL;
      end
   end

   assign w_illegal = (w_fmt == FMT_ILL);

   // Every immediate fits in 32 bits with instr[31] as its sign, so build it
   // at 32 bits and let the signed size cast extend to XLEN.
   always_comb begin
      w_imm32 = '0;
      case (w_fmt)
         FMT_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U: w_imm32 = {in_instr[31:12], 12'b0};
         FMT_J: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
         default: w_imm32 = '0;
      endcase
   end

   assign w_imm = XLEN'(w_imm32);

   always_comb begin
      w_rd_we = 1'b0;
      if ((w_fmt == FMT_R) || (w_fmt == FMT_I) ||
          (w_fmt == FMT_U) || (w_fmt == FMT_J)) begin
         w_rd_we = (in_instr[11:7] != 5'd0) && !w_illegal;
      end
   end

   assign w_bundle_in = {in_instr, in_pc, w_fmt, w_imm, w_rd_we, w_illegal};

   //------------------------------------------------------------------------
   // Output register and handshake
   //------------------------------------------------------------------------
   logic              r_valid;
   logic [BW-1:0]     r_bundle;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_in_xfer;
   logic              w_out_xfer;

   assign w_out_xfer = r_valid && out_ready;

`ifdef DECODE_SKID_BUF_EN
   logic              r_sk_valid;
   logic [BW-1:0]     r_sk_bundle;
   logic              r_in_ready;
   logic              w_slot_free;

   // r_in_ready always mirrors !r_sk_valid; it is kept as its own flop so
   // the fetch side sees a clean registered ready.
   assign in_ready    = r_in_ready;
   assign w_in_xfer   = in_valid && r_in_ready;
   assign w_slot_free = !r_valid || out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_bundle    <= '0;
         r_sk_valid  <= 1'b0;
         r_sk_bundle <= '0;
         r_in_ready  <= 1'b1;
      end else if (flush) begin
         r_valid    <= 1'b0;
         r_sk_valid <= 1'b0;
         r_in_ready <= 1'b1;
      end else if (w_slot_free) begin
         if (r_sk_valid) begin
            // Skid entry is older than anything at the input; while it is
            // occupied in_ready is low, so no input can arrive this cycle.
            r_valid    <= 1'b1;
            r_bundle   <= r_sk_bundle;
            r_sk_valid <= 1'b0;
            r_in_ready <= 1'b1;
         end else if (w_in_xfer) begin
            r_valid  <= 1'b1;
            r_bundle <= w_bundle_in;
         end else begin
            r_valid <= 1'b0;
         end
      end else if (w_in_xfer) begin
         // Output stalled: park the new bundle and close the input.
         r_sk_valid  <= 1'b1;
         r_sk_bundle <= w_bundle_in;
         r_in_ready  <= 1'b0;
      end
   end
`else
   assign in_ready  = !r_valid || out_ready;
   assign w_in_xfer = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_bundle <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_in_xfer) begin
         r_valid  <= 1'b1;
         r_bundle <= w_bundle_in;
      end else if (w_out_xfer) begin
         r_valid <= 1'b0;
      end
   end
`endif

   // Output transfers count even when a flush lands on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_out_xfer) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   //------------------------------------------------------------------------
   // Output unpacking
   //------------------------------------------------------------------------
   logic [31:0] w_q_instr;

   assign {w_q_instr, out_pc, fmt, imm, rd_we, illegal} = r_bundle;

   assign out_valid = r_valid;
   assign dec_count = r_cnt;
   assign opcode    = w_q_instr[6:0];
   assign rd        = w_q_instr[11:7];
   assign funct3    = w_q_instr[14:12];
   assign rs1       = w_q_instr[19:15];
   assign rs2       = w_q_instr[24:20];
   assign funct7    = w_q_instr[31:25];

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
//============================================================================
// Module   : tb_decode_stage
// Purpose  : Self-checking bench for decode_stage. A 32-bit instance with
//            the default counter and a 64-bit instance with a 4-bit counter
//            share the same stimulus.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_decode_stage;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  fmt;
      logic [31:0] imm;
      logic        rd_we;
      logic        ill;
   } vec_t;

   localparam int NVEC = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, rd_we, illegal;
   logic [31:0] out_pc, imm;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3, fmt;
   logic [15:0] dec_count;

   logic [63:0] in_pc_64;
   logic        in_ready_64, out_valid_64, rd_we_64, illegal_64;
   logic [63:0] out_pc_64, imm_64;
   logic [6:0]  opcode_64, funct7_64;
   logic [4:0]  rd_64, rs1_64, rs2_64;
   logic [2:0]  funct3_64, fmt_64;
   logic [3:0]  dec_count_64;

   logic [100:0] bundle;

   int   n_vec = 0;
   int   n_bad = 0;
   int   exp_cnt = 0;
   vec_t tab [NVEC];

   assign in_pc_64 = {32'h0, in_pc};
   assign bundle   = {out_pc, opcode, rd, funct3, rs1, rs2, funct7, fmt, imm, rd_we, illegal};

   always #5 clk = ~clk;

   decode_stage u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
      .fmt(fmt), .imm(imm), .rd_we(rd_we), .illegal(illegal), .dec_count(dec_count)
   );

   decode_stage #(.XLEN(64), .CNT_W(4)) u_dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_64), .in_instr(in_instr), .in_pc(in_pc_64),
      .out_valid(out_valid_64), .out_ready(out_ready), .out_pc(out_pc_64),
      .opcode(opcode_64), .rd(rd_64), .funct3(funct3_64), .rs1(rs1_64), .rs2(rs2_64),
      .funct7(funct7_64), .fmt(fmt_64), .imm(imm_64), .rd_we(rd_we_64),
      .illegal(illegal_64), .dec_count(dec_count_64)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Full check of a presented bundle; the caller guarantees it transfers
   // on the coming edge, so the expected count advances afterwards.
   task automatic check_vec(input vec_t v, input logic [31:0] pc);
      logic [63:0] imm64;
      imm64 = {{32{v.imm[31]}}, v.imm};
      chk("out_valid", 128'(out_valid), 128'(1'b1));
      chk("in_ready",  128'(in_ready),  128'(1'b1));
      chk("out_pc",    128'(out_pc),    128'(pc));
      chk("opcode",    128'(opcode),    128'(v.instr[6:0]));
      chk("rd",        128'(rd),        128'(v.instr[11:7]));
      chk("funct3",    128'(funct3),    128'(v.instr[14:12]));
      chk("rs1",       128'(rs1),       128'(v.instr[19:15]));
      chk("rs2",       128'(rs2),       128'(v.instr[24:20]));
      chk("funct7",    128'(funct7),    128'(v.instr[31:25]));
      chk("fmt",       128'(fmt),       128'(v.fmt));
      chk("imm",       128'(imm),       128'(v.imm));
      chk("rd_we",     128'(rd_we),     128'(v.rd_we));
      chk("illegal",   128'(illegal),   128'(v.ill));
      chk("imm_64",    128'(imm_64),    128'(imm64));
      chk("fmt_64",    128'(fmt_64),    128'(v.fmt));
      chk("dec_count", 128'(dec_count), 128'(exp_cnt));
      chk("cnt_64",    128'(dec_count_64), 128'(exp_cnt % 16));
      exp_cnt++;
   endtask

   // Four instructions with a three-cycle output stall, scoreboarded.
   task automatic run_stream();
      vec_t        q[$];
      logic [31:0] qpc[$];
      vec_t        e;
      logic [31:0] epc;
      logic [100:0] snap;
      logic        m_ov, m_sk, ox, ix, stall_prev;
      int          sent, got;
      m_ov = 1'b0; m_sk = 1'b0; stall_prev = 1'b0; sent = 0; got = 0; snap = '0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         @(negedge clk);
         chk("bp_out_valid", 128'(out_valid), 128'(m_ov));
`ifdef DECODE_SKID_BUF_EN
         chk("bp_in_ready", 128'(in_ready), 128'(!m_sk));
`endif
         if (stall_prev) chk("bp_hold", {27'b0, bundle}, {27'b0, snap});
         out_ready = !(cyc >= 1 && cyc <= 3);
         in_valid  = (sent < 4);
         if (sent < 4) begin
            in_instr = tab[sent].instr;
            in_pc    = 32'h2000 + 32'(4 * sent);
         end
         #1;
`ifndef DECODE_SKID_BUF_EN
         chk("bp_in_ready", 128'(in_ready), 128'(!m_ov || out_ready));
`endif
         ox = out_valid && out_ready;
         ix = in_valid && in_ready;
         if (ox) begin
            e   = q.pop_front();
            epc = qpc.pop_front();
            chk("bp_pc",     128'(out_pc), 128'(epc));
            chk("bp_opcode", 128'(opcode), 128'(e.instr[6:0]));
            chk("bp_imm",    128'(imm),    128'(e.imm));
            chk("bp_count",  128'(dec_count), 128'(exp_cnt));
            chk("bp_cnt_64", 128'(dec_count_64), 128'(exp_cnt % 16));
            got++;
            exp_cnt++;
         end
         if (ix) begin
            q.push_back(tab[sent]);
            qpc.push_back(in_pc);
            sent++;
         end
         stall_prev = out_valid && !out_ready;
         snap       = bundle;
`ifdef DECODE_SKID_BUF_EN
         if (!m_ov || ox) begin
            if (m_sk) begin m_ov = 1'b1; m_sk = 1'b0; end
            else m_ov = ix;
         end else if (ix) begin
            m_sk = 1'b1;
         end
`else
         m_ov = ix || (m_ov && !ox);
`endif
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_all_received", 128'(got), 128'(4));
      @(negedge clk);
      chk("bp_final_count", 128'(dec_count), 128'(exp_cnt));
      chk("bp_final_valid", 128'(out_valid), 128'(1'b0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tab[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b1, 1'b0}; // addi x1,x0,-1
      tab[1]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0, 1'b0}; // beq -4
      tab[2]  = '{32'hFF9FF06F, 3'd5, 32'hFFFFFFF8, 1'b0, 1'b0}; // jal x0,-8
      tab[3]  = '{32'h123452B7, 3'd4, 32'h12345000, 1'b1, 1'b0}; // lui x5
      tab[4]  = '{32'h00000000, 3'd7, 32'h00000000, 1'b0, 1'b1}; // all zero
      tab[5]  = '{32'h00A000FF, 3'd7, 32'h00000000, 1'b0, 1'b1}; // opcode 7F, rd=1
      tab[6]  = '{32'h002081B3, 3'd0, 32'h00000000, 1'b1, 1'b0}; // add x3,x1,x2
      tab[7]  = '{32'h0020A423, 3'd2, 32'h00000008, 1'b0, 1'b0}; // sw x2,8(x1)
      tab[8]  = '{32'hFE20AE23, 3'd2, 32'hFFFFFFFC, 1'b0, 1'b0}; // sw x2,-4(x1)
      tab[9]  = '{32'h80000517, 3'd4, 32'h80000000, 1'b1, 1'b0}; // auipc x10
      tab[10] = '{32'h00002003, 3'd1, 32'h00000000, 1'b0, 1'b0}; // lw x0,0(x0)
      tab[11] = '{32'h00000073, 3'd1, 32'h00000000, 1'b0, 1'b0}; // ecall
      tab[12] = '{32'h010100E7, 3'd1, 32'h00000010, 1'b1, 1'b0}; // jalr x1,16(x2)
      tab[13] = '{32'h00000012, 3'd7, 32'h00000000, 1'b0, 1'b1}; // instr[1:0]=10
      tab[14] = '{32'h001000EF, 3'd5, 32'h00000800, 1'b1, 1'b0}; // jal x1,+2048
      tab[15] = '{32'h00209863, 3'd3, 32'h00000010, 1'b0, 1'b0}; // bne +16

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_in_ready",  128'(in_ready),  128'(1'b1));
      chk("rst_dec_count", 128'(dec_count), 128'(0));
      chk("rst_bundle",    {27'b0, bundle}, 128'(0));

      // Table, streamed back to back at full throughput
      out_ready = 1'b1;
      for (int i = 0; i <= NVEC; i++) begin
         @(negedge clk);
         if (i > 0) check_vec(tab[i-1], 32'h1000 + 32'(4 * (i - 1)));
         if (i < NVEC) begin
            in_valid = 1'b1;
            in_instr = tab[i].instr;
            in_pc    = 32'h1000 + 32'(4 * i);
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("tab_idle_valid", 128'(out_valid), 128'(1'b0));

      // Backpressure
      run_stream();

      // Flush with one bundle stalled (and one skidded when buffered)
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = tab[6].instr;
      in_pc     = 32'h3000;
      @(negedge clk);
      chk("fl_a_valid", 128'(out_valid), 128'(1'b1));
      in_instr = tab[3].instr;
      in_pc    = 32'h3004;
      @(negedge clk);
`ifdef DECODE_SKID_BUF_EN
      chk("fl_skid_full", 128'(in_ready), 128'(1'b0));
`endif
      in_valid = 1'b0;
      flush    = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fl_out_valid", 128'(out_valid), 128'(1'b0));
      chk("fl_in_ready",  128'(in_ready),  128'(1'b1));
      chk("fl_count",     128'(dec_count), 128'(exp_cnt));
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("fl_nothing_emitted", 128'(out_valid), 128'(1'b0));
      end

      // Flush coinciding with an output and an input transfer
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = tab[0].instr;
      in_pc     = 32'h4000;
      @(negedge clk);
      chk("flx_valid", 128'(out_valid), 128'(1'b1));
      in_instr  = tab[1].instr;
      in_pc     = 32'h4004;
      out_ready = 1'b1;
      flush     = 1'b1;
      exp_cnt++;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flx_out_valid", 128'(out_valid), 128'(1'b0));
      chk("flx_count",     128'(dec_count), 128'(exp_cnt));
      chk("flx_cnt_64",    128'(dec_count_64), 128'(exp_cnt % 16));
      @(negedge clk);
      chk("flx_dropped", 128'(out_valid), 128'(1'b0));

      // Asynchronous reset with a bundle held at the output
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = tab[3].instr;
      in_pc     = 32'h5000;
      @(negedge clk);
      in_valid = 1'b0;
      chk("ar_valid_before", 128'(out_valid), 128'(1'b1));
      #2 rst = 1'b1;
      #1;
      chk("ar_out_valid", 128'(out_valid), 128'(1'b0));
      chk("ar_in_ready",  128'(in_ready),  128'(1'b1));
      chk("ar_dec_count", 128'(dec_count), 128'(0));
      chk("ar_imm",       128'(imm),       128'(0));
      exp_cnt = 0;
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("ar_no_partial", 128'(out_valid), 128'(1'b0));
      in_valid = 1'b1;
      in_instr = tab[0].instr;
      in_pc    = 32'h6000;
      @(negedge clk);
      in_valid = 1'b0;
      check_vec(tab[0], 32'h6000);
      @(negedge clk);
      chk("ar_post_count", 128'(dec_count), 128'(exp_cnt));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
